xor_fixed: RTL and testbench
============================

// Module: xor_fixed
// PURPOSE
//  2-2-1 step-activation perceptron network computing XOR on four sample pairs in parallel.
//  Fixed-point datapath; evaluation only, no training. Weights are supplied as inputs.
//  Two-stage registered pipeline: hidden layer, then output layer. Float twin is a separate block.
// PARAMETERS
//  tam   16  word width; sign-magnitude: [tam-1]=sign, then 3 integer bits, then FRAC fraction bits
//  FRAC  12  fraction bits (tam-1-FRAC = 3 integer bits); 1.0 = 16'h1000, -0.5 = 16'h8800
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous active-low reset
//  in_valid  in   1      in1/in2/weights valid this cycle
//  in1       in   4*tam  sample k in [k*tam +: tam], k=0..3, values 0 or 1.0
//  in2       in   4*tam  as in1
//  w01,w11,w21 in tam    hidden neuron 1: bias, weight on in2, weight on in1
//  w02,w12,w22 in tam    hidden neuron 2: bias, weight on in2, weight on in1
//  w0,w1,w2  in   tam    output neuron: bias, weight on z1, weight on z2
//  out_valid out  1      result valid
//  result    out  4*tam  result for sample k in [k*tam +: tam]: 0 or 1.0
// BEHAVIOUR
//  - Per sample k: z1 = step(w01 + w11*in2 + w21*in1); z2 = step(w02 + w12*in2 + w22*in1);
//    y = step(w0 + w1*z1 + w2*z2).
//  - step(s) = 1.0 (16'h1000) if s >= 0, including negative zero (16'h8000); else 16'h0000.
//  - Multiply: sign = XOR of signs; magnitude = (|a|*|b|) >> FRAC, truncated;
//    saturate to all-ones magnitude on overflow; zero magnitude forces sign 0.
//  - Add: sign-magnitude. Equal signs: add magnitudes, saturate on overflow.
//    Opposite signs: subtract smaller magnitude from larger; take sign of larger. Zero result forces sign 0.
//    Sum evaluated left to right: (bias + p1) + p2.
//  - Stage 1 (edge when in_valid=1): registers z1[k], z2[k], w0/w1/w2, and v1 <= 1.
//  - Stage 1 (edge when in_valid=0): v1 <= 0 and data registers hold.
//  - Stage 2 (each edge): result <= y computed from stage-1 registers; out_valid <= v1.
//  - Latency 2 cycles. Throughput 1 per cycle; back-to-back in_valid is legal; no backpressure.
//  - result holds its last value while out_valid=0.
//  - Reset: all registers clear asynchronously; result=0, out_valid=0, hidden registers=0.
//    Reset mid-operation discards in-flight samples; first out_valid follows 2 edges after a valid input.
//  - in1/in2 values other than 0 and 1.0 are computed arithmetically as above; no checking.
// CONFIGURATION
//  XOR_HIDDEN_OUT_EN defined: adds output ports z1_out and z2_out (4*tam each).
//    They carry the stage-1 hidden registers (0 or 1.0), are aligned to out_valid
//    (delayed one extra register), and reset to 0.
//  Not defined: ports absent; hidden values are internal only.
// TESTING
//  1 Truth table: in1={1.0,0,1.0,0}, in2={1.0,1.0,0,0} (k=3..0);
//    w01=8800 w11=0800 w21=9000, w02=8800 w12=8800 w22=0800, w0=8800 w1=0800 w2=0800
//    -> 2 cycles later result k0..3 = 0000,1000,1000,0000; out_valid=1 for one cycle.
//  2 XOR_HIDDEN_OUT_EN with test 1 stimulus -> z1 k0..3 = 0,0,1000,0; z2 = 0,1000,0,0.
//  3 Step boundary: w0=0000 w1=w2=0000 -> all results 1000;
//    w0=8000 (negative zero) -> 1000; w0=8001 -> 0000.
//  4 Saturation: w21=7FFF, in1=1.0, in2=0, w01=7FFF -> hidden sum saturates positive, z1=1000;
//    w21=FFFF, w01=FFFF -> z1=0.
//  5 Streaming: in_valid high 3 cycles with distinct patterns -> 3 consecutive out_valid,
//    results in order; in_valid gap -> out_valid gap.
//  6 Reset: assert rst_n=0 asynchronously mid-pipeline -> result=0, out_valid=0 immediately;
//    no stale out_valid after release.

Source files
------------

// File: rtl/xor_fixed.sv
// xor_fixed: 2-2-1 step-activation perceptron evaluating XOR on four lanes in parallel.
// Sign-magnitude fixed point: [tam-1] sign, 3 integer bits, FRAC fraction bits.
// Two register stages: hidden layer (z1/z2), then output layer (result).
// Optional feature macro: XOR_HIDDEN_OUT_EN exposes the hidden-layer values on
// z1_out/z2_out, delayed so that they line up with out_valid.
module xor_fixed #(
   parameter int tam  = 16,
   parameter int FRAC = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [4*tam-1:0]  in1,
   input  logic [4*tam-1:0]  in2,
   input  logic [tam-1:0]    w01,
   input  logic [tam-1:0]    w11,
   input  logic [tam-1:0]    w21,
   input  logic [tam-1:0]    w02,
   input  logic [tam-1:0]    w12,
   input  logic [tam-1:0]    w22,
   input  logic [tam-1:0]    w0,
   input  logic [tam-1:0]    w1,
   input  logic [tam-1:0]    w2,
   output logic              out_valid,
   output logic [4*tam-1:0]  result
`ifdef XOR_HIDDEN_OUT_EN
  ,output logic [4*tam-1:0]  z1_out,
   output logic [4*tam-1:0]  z2_out
`endif
);

   localparam int MAG_W = tam - 1;
   localparam logic [tam-1:0] ONE = {{(tam-1-FRAC){1'b0}}, 1'b1, {FRAC{1'b0}}};

   // Clamp a wide unsigned magnitude to the largest representable magnitude.
   function automatic logic [MAG_W-1:0] sat_mag(input logic [2*MAG_W-1:0] wide);
      if (|wide[2*MAG_W-1:MAG_W])
         return {MAG_W{1'b1}};
      return wide[MAG_W-1:0];
   endfunction

   // Sign-magnitude multiply: truncated fixed-point product, saturated, zero is positive.
   function automatic logic [tam-1:0] sm_mul(input logic [tam-1:0] a, input logic [tam-1:0] b);
      logic [2*MAG_W-1:0] prod;
      logic [MAG_W-1:0]   mag;
      prod = {{MAG_W{1'b0}}, a[MAG_W-1:0]} * {{MAG_W{1'b0}}, b[MAG_W-1:0]};
      mag  = sat_mag(prod >> FRAC);
      return {(mag != '0) & (a[tam-1] ^ b[tam-1]), mag};
   endfunction

   // Sign-magnitude add: like signs add with saturation, unlike signs subtract
   // the smaller magnitude from the larger and keep the larger operand's sign.
   function automatic logic [tam-1:0] sm_add(input logic [tam-1:0] a, input logic [tam-1:0] b);
      logic [MAG_W:0]   sum;
      logic [MAG_W-1:0] am;
      logic [MAG_W-1:0] bm;
      logic [MAG_W-1:0] mag;
      logic             sgn;
      sum = '0;
      am  = a[MAG_W-1:0];
      bm  = b[MAG_W-1:0];
      if (a[tam-1] == b[tam-1]) begin
         sum = {1'b0, am} + {1'b0, bm};
         mag = sat_mag({{(MAG_W-1){1'b0}}, sum});
         sgn = a[tam-1];
      end else if (am >= bm) begin
         mag = am - bm;
         sgn = a[tam-1];
      end else begin
         mag = bm - am;
         sgn = b[tam-1];
      end
      return {(mag != '0) & sgn, mag};
   endfunction

   // Step activation: any non-negative value, negative zero included, fires 1.0.
   function automatic logic [tam-1:0] sm_step(input logic [tam-1:0] s);
      if (!s[tam-1] || (s[MAG_W-1:0] == '0))
         return ONE;
      return '0;
   endfunction

   // One neuron: step((bias + wa*xa) + wb*xb), summed strictly left to right
   // because saturation makes the addition non-associative.
   function automatic logic [tam-1:0] neuron(input logic [tam-1:0] bias,
                                             input logic [tam-1:0] wa, input logic [tam-1:0] xa,
                                             input logic [tam-1:0] wb, input logic [tam-1:0] xb);
      return sm_step(sm_add(sm_add(bias, sm_mul(wa, xa)), sm_mul(wb, xb)));
   endfunction

   logic [4*tam-1:0] z1_c;
   logic [4*tam-1:0] z2_c;
   logic [4*tam-1:0] y_c;

   logic [4*tam-1:0] z1_p1;
   logic [4*tam-1:0] z2_p1;
   logic [tam-1:0]   w0_p1;
   logic [tam-1:0]   w1_p1;
   logic [tam-1:0]   w2_p1;
   logic             vld_p1;

   logic [4*tam-1:0] result_p2;
   logic             vld_p2;

   for (genvar k = 0; k < 4; k++) begin : g_lane
      assign z1_c[k*tam +: tam] = neuron(w01, w11, in2[k*tam +: tam], w21, in1[k*tam +: tam]);
      assign z2_c[k*tam +: tam] = neuron(w02, w12, in2[k*tam +: tam], w22, in1[k*tam +: tam]);
      assign y_c[k*tam +: tam]  = neuron(w0_p1, w1_p1, z1_p1[k*tam +: tam],
                                         w2_p1, z2_p1[k*tam +: tam]);
   end

   // ---- stage 1: hidden layer; data captured only on a valid input ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z1_p1  <= '0;
         z2_p1  <= '0;
         w0_p1  <= '0;
         w1_p1  <= '0;
         w2_p1  <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            z1_p1 <= z1_c;
            z2_p1 <= z2_c;
            w0_p1 <= w0;
            w1_p1 <= w1;
            w2_p1 <= w2;
         end
      end
   end

   // ---- stage 2: output layer; result only moves when a sample completes ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_p2 <= '0;
         vld_p2    <= 1'b0;
      end else begin
         vld_p2 <= vld_p1;
         if (vld_p1)
            result_p2 <= y_c;
      end
   end

   assign result    = result_p2;
   assign out_valid = vld_p2;

`ifdef XOR_HIDDEN_OUT_EN
   logic [4*tam-1:0] z1_p2;
   logic [4*tam-1:0] z2_p2;

   // ---- stage 2: hidden values re-registered to line up with result ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z1_p2 <= '0;
         z2_p2 <= '0;
      end else if (vld_p1) begin
         z1_p2 <= z1_p1;
         z2_p2 <= z2_p1;
      end
   end

   assign z1_out = z1_p2;
   assign z2_out = z2_p2;
`endif

endmodule

// File: tb/tb_xor_fixed.sv
// tb_xor_fixed: scoreboard bench for xor_fixed. Stimulus pushes expected results
// (integer-arithmetic reference model or hand-derived constants) into a queue; a
// monitor on the falling edge pops and compares whenever out_valid is high.
module tb_xor_fixed;

   typedef struct packed {
      logic [63:0] res;
      logic [63:0] z1;
      logic [63:0] z2;
   } exp_t;

   localparam logic [63:0] ALL1 = 64'h1000_1000_1000_1000;
   localparam logic [63:0] T1_IN1 = {16'h1000, 16'h0000, 16'h1000, 16'h0000};
   localparam logic [63:0] T1_IN2 = {16'h1000, 16'h1000, 16'h0000, 16'h0000};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [63:0] in1, in2;
   logic [15:0] w01, w11, w21, w02, w12, w22, w0, w1, w2;
   logic        out_valid;
   logic [63:0] result;
`ifdef XOR_HIDDEN_OUT_EN
   logic [63:0] z1_out, z2_out;
`endif

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t q[$];
   exp_t mon_e;
   logic [63:0] last_res = '0;
   logic vh0, vh1;

   xor_fixed dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in1(in1), .in2(in2),
      .w01(w01), .w11(w11), .w21(w21), .w02(w02), .w12(w12), .w22(w22),
      .w0(w0), .w1(w1), .w2(w2), .out_valid(out_valid), .result(result)
`ifdef XOR_HIDDEN_OUT_EN
     ,.z1_out(z1_out), .z2_out(z2_out)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: values as plain integers in units of 2^-12, clamped to +/-32767.
   function automatic int to_int(input logic [15:0] x);
      return x[15] ? -int'(x[14:0]) : int'(x[14:0]);
   endfunction

   function automatic int clampv(input int v);
      if (v > 32767) return 32767;
      if (v < -32767) return -32767;
      return v;
   endfunction

   function automatic int mul_m(input int a, input int b);
      int m;
      m = ((a < 0 ? -a : a) * (b < 0 ? -b : b)) >>> 12;
      if (m > 32767) m = 32767;
      return ((a < 0) != (b < 0)) ? -m : m;
   endfunction

   function automatic logic [15:0] neuron_m(input int b, input int wa, input int xa,
                                            input int wb, input int xb);
      int s;
      s = clampv(clampv(b + mul_m(wa, xa)) + mul_m(wb, xb));
      return (s >= 0) ? 16'h1000 : 16'h0000;
   endfunction

   function automatic exp_t model(input logic [63:0] i1, input logic [63:0] i2);
      exp_t e;
      logic [15:0] z1, z2;
      for (int k = 0; k < 4; k++) begin
         z1 = neuron_m(to_int(w01), to_int(w11), to_int(i2[k*16 +: 16]),
                       to_int(w21), to_int(i1[k*16 +: 16]));
         z2 = neuron_m(to_int(w02), to_int(w12), to_int(i2[k*16 +: 16]),
                       to_int(w22), to_int(i1[k*16 +: 16]));
         e.z1[k*16 +: 16]  = z1;
         e.z2[k*16 +: 16]  = z2;
         e.res[k*16 +: 16] = neuron_m(to_int(w0), to_int(w1), to_int(z1), to_int(w2), to_int(z2));
      end
      return e;
   endfunction

   function automatic logic [15:0] pick_w();
      case ($urandom_range(0, 9))
         0: return 16'h0000;
         1: return 16'h0800;
         2: return 16'h8800;
         3: return 16'h1000;
         4: return 16'h9000;
         5: return 16'h8000;
         6: return 16'h7FFF;
         7: return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   function automatic logic [63:0] rand_in();
      logic [63:0] v;
      int r;
      for (int k = 0; k < 4; k++) begin
         r = $urandom_range(0, 9);
         v[k*16 +: 16] = (r == 0) ? 16'($urandom) : ((r < 5) ? 16'h1000 : 16'h0000);
      end
      return v;
   endfunction

   task automatic drive(input logic [63:0] i1, input logic [63:0] i2, input exp_t e);
      in1 = i1;
      in2 = i2;
      in_valid = 1'b1;
      q.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send(input logic [63:0] i1, input logic [63:0] i2);
      drive(i1, i2, model(i1, i2));
   endtask

   task automatic send_c(input logic [63:0] i1, input logic [63:0] i2,
                         input logic [63:0] r, input logic [63:0] z1, input logic [63:0] z2);
      exp_t e;
      e.res = r;
      e.z1  = z1;
      e.z2  = z2;
      drive(i1, i2, e);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_t1();
      w01 = 16'h8800; w11 = 16'h0800; w21 = 16'h9000;
      w02 = 16'h8800; w12 = 16'h8800; w22 = 16'h0800;
      w0  = 16'h8800; w1  = 16'h0800; w2  = 16'h0800;
   endtask

   task automatic rand_w();
      w01 = pick_w(); w11 = pick_w(); w21 = pick_w();
      w02 = pick_w(); w12 = pick_w(); w22 = pick_w();
      w0  = pick_w(); w1  = pick_w(); w2  = pick_w();
   endtask

   // Expected out_valid: the in_valid seen two rising edges earlier.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vh0 <= 1'b0;
         vh1 <= 1'b0;
      end else begin
         vh1 <= vh0;
         vh0 <= in_valid;
      end
   end

   // Monitor: compare every completed sample and check result holds between them.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("out_valid", {63'b0, out_valid}, {63'b0, vh1});
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_output", 64'd1, 64'd0);
            end else begin
               mon_e = q.pop_front();
               chk("result", result, mon_e.res);
`ifdef XOR_HIDDEN_OUT_EN
               chk("z1_out", z1_out, mon_e.z1);
               chk("z2_out", z2_out, mon_e.z2);
`endif
               last_res = mon_e.res;
            end
         end else begin
            chk("result_hold", result, last_res);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0;
      w01 = '0; w11 = '0; w21 = '0; w02 = '0; w12 = '0; w22 = '0; w0 = '0; w1 = '0; w2 = '0;
      #1;
      chk("reset_result", result, 64'h0);
      chk("reset_out_valid", {63'b0, out_valid}, 64'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      // Truth table
      set_t1();
      send_c(T1_IN1, T1_IN2, 64'h0000_1000_1000_0000,
             64'h0000_1000_0000_0000, 64'h0000_0000_1000_0000);
      idle(3);

      // Step boundary on the output neuron
      w0 = 16'h0000; w1 = 16'h0000; w2 = 16'h0000;
      send_c(T1_IN1, T1_IN2, ALL1, 64'h0000_1000_0000_0000, 64'h0000_0000_1000_0000);
      w0 = 16'h8000;
      send_c(T1_IN1, T1_IN2, ALL1, 64'h0000_1000_0000_0000, 64'h0000_0000_1000_0000);
      w0 = 16'h8001;
      send_c(T1_IN1, T1_IN2, 64'h0, 64'h0000_1000_0000_0000, 64'h0000_0000_1000_0000);
      idle(3);

      // Saturation in the hidden sum
      set_t1();
      w2 = 16'h0000;
      w01 = 16'h7FFF; w21 = 16'h7FFF;
      send_c(ALL1, 64'h0, ALL1, ALL1, ALL1);
      w01 = 16'hFFFF; w21 = 16'hFFFF;
      send_c(ALL1, 64'h0, 64'h0, 64'h0, ALL1);
      idle(3);

      // Streaming: three back-to-back, a gap, then two more
      for (int i = 0; i < 3; i++) begin
         rand_w();
         send(rand_in(), rand_in());
      end
      idle(2);
      for (int i = 0; i < 2; i++) begin
         rand_w();
         send(rand_in(), rand_in());
      end
      idle(3);

      // Asynchronous reset with samples in flight
      set_t1();
      w0 = 16'h0000; w1 = 16'h0000; w2 = 16'h0000;
      send_c(T1_IN1, T1_IN2, ALL1, 64'h0000_1000_0000_0000, 64'h0000_0000_1000_0000);
      idle(2);
      rand_w();
      send(rand_in(), rand_in());
      send(rand_in(), rand_in());
      #3 rst_n = 1'b0;
      #1;
      chk("midreset_result", result, 64'h0);
      chk("midreset_out_valid", {63'b0, out_valid}, 64'h0);
`ifdef XOR_HIDDEN_OUT_EN
      chk("midreset_z1", z1_out, 64'h0);
      chk("midreset_z2", z2_out, 64'h0);
`endif
      q.delete();
      last_res = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(4);

      // Randomized traffic with random gaps
      for (int i = 0; i < 150; i++) begin
         rand_w();
         if ($urandom_range(0, 3) != 0)
            send(rand_in(), rand_in());
         else
            idle(1);
      end
      idle(4);
      chk("drain_queue_empty", 64'(q.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
